// File: rtl/seg_display_scan.sv
// seg_display_scan: multiplexed 7-segment scanner with frame snapshot, LZ blanking, DPs and PWM dimming
module seg_display_scan #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] number,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  input  logic                    enable,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [7:0]              cathodes,
  output logic                    frame_start
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [PW-1:0]           r_presc, w_presc_n;
  logic [IW-1:0]           r_idx, w_idx_n;
  logic [3:0]              r_pwm, w_pwm_n, r_bright, w_bright_n, w_nib;
  logic [4*NUM_DIGITS-1:0] r_num, w_num_n;
  logic [NUM_DIGITS-1:0]   r_dp, w_dp_n, r_blank, w_blank_n, w_lead;
  logic                    r_lz, w_lz_n, r_load_pending;
  logic                    w_wrap, w_last, w_snap, w_dark, w_run;
  // Outputs are registered from the next-state values so each output cycle reflects the frame it belongs to
  assign w_wrap     = !r_load_pending && r_presc == PW'(TICK_DIV - 1);
  assign w_last     = r_idx == IW'(NUM_DIGITS - 1);
  assign w_snap     = r_load_pending || (w_wrap && w_last);
  assign w_presc_n  = (r_load_pending || w_wrap) ? '0 : r_presc + 1'b1;
  assign w_idx_n    = (r_load_pending || (w_wrap && w_last)) ? '0 : w_wrap ? r_idx + 1'b1 : r_idx;
  assign w_pwm_n    = r_pwm + 4'd1;
  assign w_num_n    = w_snap ? number      : r_num;
  assign w_dp_n     = w_snap ? dp_mask     : r_dp;
  assign w_blank_n  = w_snap ? blank_mask  : r_blank;
  assign w_lz_n     = w_snap ? lz_suppress : r_lz;
  assign w_bright_n = w_snap ? brightness  : r_bright;
  assign w_nib      = w_num_n[w_idx_n*4 +: 4];
  always_comb begin
    w_run  = 1'b1;
    w_lead = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run     = w_run && (w_num_n[4*i +: 4] == 4'd0);
      w_lead[i] = w_run;
    end
  end
  assign w_dark = !enable || w_blank_n[w_idx_n] || (w_pwm_n > w_bright_n) ||
                  (w_lz_n && w_idx_n != '0 && w_lead[w_idx_n]);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc        <= '0;
      r_idx          <= '0;
      r_pwm          <= '0;
      r_num          <= '0;
      r_dp           <= '0;
      r_blank        <= '0;
      r_lz           <= 1'b0;
      r_bright       <= '0;
      r_load_pending <= 1'b1;
      anodes         <= '1;
      cathodes       <= 8'hFF;
      frame_start    <= 1'b0;
    end else begin
      r_presc        <= w_presc_n;
      r_idx          <= w_idx_n;
      r_pwm          <= w_pwm_n;
      r_num          <= w_num_n;
      r_dp           <= w_dp_n;
      r_blank        <= w_blank_n;
      r_lz           <= w_lz_n;
      r_bright       <= w_bright_n;
      r_load_pending <= 1'b0;
      anodes         <= w_dark ? '1 : ~(NUM_DIGITS'(1) << w_idx_n);
      cathodes       <= w_dark ? 8'hFF : {SEG[w_nib], ~w_dp_n[w_idx_n]};
      frame_start    <= w_snap;
    end
  end
endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: directed check of scan order, snapshot, LZ blanking, DP/blank, PWM, enable and async reset
module tb_seg_display_scan;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] number;
  logic [7:0]  dp_mask, blank_mask;
  logic        lz_suppress;
  logic [3:0]  brightness;
  logic        enable;
  logic [7:0]  anodes, cathodes;
  logic        frame_start;
  int          n_vec = 0, n_err = 0, cyc = -1;
  logic [31:0] f_num;
  logic [7:0]  f_dp, f_blank;
  logic        f_lz;
  always #5 clk = ~clk;
  seg_display_scan #(.NUM_DIGITS(8), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .number(number), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .lz_suppress(lz_suppress), .brightness(brightness),
    .enable(enable), .anodes(anodes), .cathodes(cathodes), .frame_start(frame_start));
  function automatic logic [7:0] cat_of(input logic [3:0] nib, input logic dp);
    logic [7:0] v;
    case (nib)
      4'h0: v = 8'h03; 4'h1: v = 8'h9F; 4'h2: v = 8'h25; 4'h3: v = 8'h0D;
      4'h4: v = 8'h99; 4'h5: v = 8'h49; 4'h6: v = 8'h41; 4'h7: v = 8'h1F;
      4'h8: v = 8'h01; 4'h9: v = 8'h09; 4'hA: v = 8'h11; 4'hB: v = 8'hC1;
      4'hC: v = 8'h63; 4'hD: v = 8'h85; 4'hE: v = 8'h61; default: v = 8'h71;
    endcase
    return dp ? (v & 8'hFE) : v;
  endfunction
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [7:0] an, input logic [7:0] cat, input logic fs);
    n_vec += 3;
    assert (anodes === an) else begin
      n_err++;
      $error("FAIL %s cyc=%0d anodes got %h exp %h", tag, cyc, anodes, an);
    end
    assert (cathodes === cat) else begin
      n_err++;
      $error("FAIL %s cyc=%0d cathodes got %h exp %h", tag, cyc, cathodes, cat);
    end
    assert (frame_start === fs) else begin
      n_err++;
      $error("FAIL %s cyc=%0d frame_start got %b exp %b", tag, cyc, frame_start, fs);
    end
  endtask
  task automatic scan(input string tag, input int ncyc);
    int slot;
    logic dark;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      slot = (cyc / 4) % 8;
      dark = f_blank[slot] || (f_lz && slot != 0 && (f_num >> (4 * slot)) == 32'd0);
      chk(tag, dark ? 8'hFF : ~(8'h01 << slot),
          dark ? 8'hFF : cat_of(f_num[4*slot +: 4], f_dp[slot]), (cyc % 32) == 0);
    end
  endtask
  task automatic count_lit(input string tag, input int exp);
    int cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (anodes !== 8'hFF) cnt++;
    end
    n_vec++;
    assert (cnt === exp) else begin
      n_err++;
      $error("FAIL %s lit cycles got %0d exp %0d", tag, cnt, exp);
    end
  endtask
  initial begin
    reset = 1'b1; number = 32'h89ABCDEF; dp_mask = 8'h00; blank_mask = 8'h00;
    lz_suppress = 1'b0; brightness = 4'd15; enable = 1'b1;
    f_num = number; f_dp = 8'h00; f_blank = 8'h00; f_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", 8'hFF, 8'hFF, 1'b0);
    reset = 1'b0;
    scan("boot", 33);
    number = 32'h0;
    scan("hold", 31);
    f_num = 32'h0;
    scan("zero", 32);
    number = 32'h00000120; lz_suppress = 1'b1;
    f_num = number; f_lz = 1'b1;
    scan("lz120", 32);
    number = 32'h0; f_num = 32'h0;
    scan("lz0", 32);
    number = 32'h89ABCDEF; lz_suppress = 1'b0; dp_mask = 8'h05; blank_mask = 8'h80;
    f_num = number; f_lz = 1'b0; f_dp = 8'h05; f_blank = 8'h80;
    scan("dpblank", 32);
    dp_mask = 8'h00; blank_mask = 8'h00; brightness = 4'd3;
    count_lit("pwm3", 4);
    repeat (16) tick();
    brightness = 4'd0;
    count_lit("pwm0", 1);
    repeat (16) tick();
    brightness = 4'd15;
    count_lit("pwm15", 16);
    enable = 1'b0;
    tick();
    chk("disable", 8'hFF, 8'hFF, 1'b0);
    repeat (7) tick();
    enable = 1'b1;
    tick();
    chk("reenable", 8'hBF, 8'h09, 1'b0);
    #2 reset = 1'b1;
    #1 chk("async_rst", 8'hFF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = -1;
    tick();
    chk("restart", 8'hFE, 8'h71, 1'b1);
    repeat (3) tick();
    tick();
    chk("restart_d1", 8'hFD, 8'h61, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
